// File: rtl/branch_prediction_resolver_pkg.sv
// Shared widths, constants and the pipeline stage record for the branch prediction resolver.
package branch_prediction_resolver_pkg;

  localparam int unsigned PC_WIDTH  = 32;
  localparam int unsigned CNT_WIDTH = 16;
  localparam int unsigned PC_INCR   = 4;

  typedef struct packed {
    logic                valid;
    logic [PC_WIDTH-1:0] pc;
    logic                hit;
    logic                predict;
    logic [PC_WIDTH-1:0] target;
  } stage_t;

  // A fetch was steered to the BTB target only when the BTB hit and the counter said taken.
  function automatic logic pred_taken(input stage_t s);
    return s.hit & s.predict;
  endfunction

endpackage

// File: rtl/branch_prediction_resolver_if.sv
// Fetch, execute-resolution and predictor-update signals of the branch prediction resolver.
interface branch_prediction_resolver_if;
  import branch_prediction_resolver_pkg::*;

  logic                 IF_Valid;
  logic [PC_WIDTH-1:0]  IF_PC;
  logic                 IF_Hit;
  logic                 IF_JumpPredict;
  logic [PC_WIDTH-1:0]  IF_PredTarget;
  logic                 Stall;
  logic                 EX_IsBranch;
  logic                 EX_Taken;
  logic [PC_WIDTH-1:0]  EX_Target;

  logic                 Mispredict;
  logic [PC_WIDTH-1:0]  RedirectPC;
  logic                 EX_Hit;
  logic                 Success;
  logic                 BTB_Write;
  logic [PC_WIDTH-1:0]  BTB_WrPC;
  logic [PC_WIDTH-1:0]  BTB_WrTarget;
  logic [CNT_WIDTH-1:0] BranchCount;
  logic [CNT_WIDTH-1:0] MissCount;

  modport master (
    output IF_Valid, IF_PC, IF_Hit, IF_JumpPredict, IF_PredTarget, Stall,
           EX_IsBranch, EX_Taken, EX_Target,
    input  Mispredict, RedirectPC, EX_Hit, Success, BTB_Write, BTB_WrPC,
           BTB_WrTarget, BranchCount, MissCount
  );

  modport slave (
    input  IF_Valid, IF_PC, IF_Hit, IF_JumpPredict, IF_PredTarget, Stall,
           EX_IsBranch, EX_Taken, EX_Target,
    output Mispredict, RedirectPC, EX_Hit, Success, BTB_Write, BTB_WrPC,
           BTB_WrTarget, BranchCount, MissCount
  );

endinterface

// File: rtl/branch_prediction_resolver_stage.sv
// One prediction pipeline register; clear beats hold, hold beats load.
module bp_pipe_stage
  import branch_prediction_resolver_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   hold,
  input  logic   clear,
  input  stage_t d,
  output stage_t q
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      q <= '0;
    end else if (hold) begin
      q <= q;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/branch_prediction_resolver.sv
// Carries fetch-time predictions to EX, checks them against the real outcome, and drives
// flush/redirect, predictor and BTB updates plus branch/miss statistics.
module branch_prediction_resolver
  import branch_prediction_resolver_pkg::*;
(
  input  logic                        CLK,
  input  logic                        Reset,
  branch_prediction_resolver_if.slave bus
);

  stage_t               if_rec;
  stage_t               ifid;
  stage_t               idex;
  logic                 active;
  logic                 taken_pred;
  logic                 target_diff;
  logic                 mispredict;
  logic                 ex_hit;
  logic                 success;
  logic                 btb_write;
  logic [PC_WIDTH-1:0]  redirect_pc;
  logic [PC_WIDTH-1:0]  wr_pc;
  logic [PC_WIDTH-1:0]  wr_target;
  logic [CNT_WIDTH-1:0] branch_count;
  logic [CNT_WIDTH-1:0] miss_count;

  // An idle fetch slot enters IF/ID as an all-zero bubble.
  always_comb begin
    if_rec = '0;
    if (bus.IF_Valid) begin
      if_rec.valid   = 1'b1;
      if_rec.pc      = bus.IF_PC;
      if_rec.hit     = bus.IF_Hit;
      if_rec.predict = bus.IF_JumpPredict;
      if_rec.target  = bus.IF_PredTarget;
    end
  end

  bp_pipe_stage u_if_id (
    .clk   (CLK),
    .rst   (Reset),
    .load  (!bus.Stall),
    .hold  (bus.Stall),
    .clear (mispredict),
    .d     (if_rec),
    .q     (ifid)
  );

  bp_pipe_stage u_id_ex (
    .clk   (CLK),
    .rst   (Reset),
    .load  (!bus.Stall),
    .hold  (bus.Stall),
    .clear (mispredict),
    .d     (ifid),
    .q     (idex)
  );

  // Resolution compares the ID/EX prediction with the EX outcome in the same cycle.
  always_comb begin
    active      = idex.valid & ~bus.Stall;
    taken_pred  = pred_taken(idex);
    target_diff = (idex.target != bus.EX_Target);
    mispredict  = 1'b0;
    redirect_pc = '0;
    ex_hit      = 1'b0;
    success     = 1'b0;
    btb_write   = 1'b0;
    wr_pc       = '0;
    wr_target   = '0;
    if (active) begin
      if (bus.EX_IsBranch) begin
        mispredict = (taken_pred != bus.EX_Taken) | (taken_pred & bus.EX_Taken & target_diff);
      end else begin
        mispredict = taken_pred;
      end
      if (mispredict) begin
        redirect_pc = (bus.EX_IsBranch & bus.EX_Taken) ? bus.EX_Target
                                                       : idex.pc + PC_WIDTH'(PC_INCR);
      end
      ex_hit    = bus.EX_IsBranch & idex.hit;
      success   = ex_hit & bus.EX_Taken;
      btb_write = bus.EX_IsBranch & bus.EX_Taken & (~idex.hit | target_diff);
      if (btb_write) begin
        wr_pc     = idex.pc;
        wr_target = bus.EX_Target;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      branch_count <= '0;
      miss_count   <= '0;
    end else if (active) begin
      if (bus.EX_IsBranch) begin
        branch_count <= branch_count + CNT_WIDTH'(1);
      end
      if (mispredict) begin
        miss_count <= miss_count + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.Mispredict   = mispredict;
  assign bus.RedirectPC   = redirect_pc;
  assign bus.EX_Hit       = ex_hit;
  assign bus.Success      = success;
  assign bus.BTB_Write    = btb_write;
  assign bus.BTB_WrPC     = wr_pc;
  assign bus.BTB_WrTarget = wr_target;
  assign bus.BranchCount  = branch_count;
  assign bus.MissCount    = miss_count;

endmodule

// File: tb/tb_branch_prediction_resolver.sv
// Directed-vector bench for branch_prediction_resolver: the driver queues hand-computed
// per-cycle responses and an independent negedge monitor pops and compares them.
module tb_branch_prediction_resolver;

  typedef struct packed {
    logic        mis;
    logic [31:0] rpc;
    logic        exh;
    logic        suc;
    logic        bw;
    logic [31:0] wpc;
    logic [31:0] wtg;
    logic [15:0] bc;
    logic [15:0] mc;
  } resp_t;

  localparam int L = 65540;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  resp_t exp_q[$];
  string name_q[$];

  branch_prediction_resolver_if bus();

  branch_prediction_resolver dut (
    .CLK   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic resp_t r(input logic mis, input logic [31:0] rpc, input logic exh,
                              input logic suc, input logic bw, input logic [31:0] wpc,
                              input logic [31:0] wtg, input logic [15:0] bc,
                              input logic [15:0] mc);
    resp_t e;
    e.mis = mis; e.rpc = rpc; e.exh = exh; e.suc = suc; e.bw = bw;
    e.wpc = wpc; e.wtg = wtg; e.bc = bc; e.mc = mc;
    return e;
  endfunction

  function automatic resp_t z(input logic [15:0] bc, input logic [15:0] mc);
    return r(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, bc, mc);
  endfunction

  task automatic step(input string nm, input logic rs, input logic ifv, input logic [31:0] pc,
                      input logic hit, input logic prd, input logic [31:0] tgt,
                      input logic stall, input logic br, input logic tk,
                      input logic [31:0] etgt, input resp_t e);
    @(posedge clk);
    #1;
    rst                = rs;
    bus.IF_Valid       = ifv;
    bus.IF_PC          = pc;
    bus.IF_Hit         = hit;
    bus.IF_JumpPredict = prd;
    bus.IF_PredTarget  = tgt;
    bus.Stall          = stall;
    bus.EX_IsBranch    = br;
    bus.EX_Taken       = tk;
    bus.EX_Target      = etgt;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic fetch(input string nm, input logic [31:0] pc, input logic hit,
                       input logic prd, input logic [31:0] tgt, input resp_t e);
    step(nm, 1'b0, 1'b1, pc, hit, prd, tgt, 1'b0, 1'b0, 1'b0, 32'h0, e);
  endtask

  task automatic idle(input string nm, input resp_t e);
    step(nm, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, e);
  endtask

  task automatic resolve(input string nm, input logic stall, input logic br, input logic tk,
                         input logic [31:0] etgt, input resp_t e);
    step(nm, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, stall, br, tk, etgt, e);
  endtask

  // Monitor: compares every queued expectation against what the DUT shows mid-cycle.
  always @(negedge clk) begin : monitor
    resp_t e;
    resp_t a;
    string n;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a.mis = bus.Mispredict;  a.rpc = bus.RedirectPC; a.exh = bus.EX_Hit;
      a.suc = bus.Success;     a.bw = bus.BTB_Write;   a.wpc = bus.BTB_WrPC;
      a.wtg = bus.BTB_WrTarget; a.bc = bus.BranchCount; a.mc = bus.MissCount;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got mis=%b rpc=%h exh=%b suc=%b bw=%b wpc=%h wtg=%h bc=%h mc=%h ; expected mis=%b rpc=%h exh=%b suc=%b bw=%b wpc=%h wtg=%h bc=%h mc=%h",
                 n, a.mis, a.rpc, a.exh, a.suc, a.bw, a.wpc, a.wtg, a.bc, a.mc,
                 e.mis, e.rpc, e.exh, e.suc, e.bw, e.wpc, e.wtg, e.bc, e.mc);
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, got pending=%0d expected 0", exp_q.size());
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    rst = 1'b1;
    bus.IF_Valid = 1'b0; bus.IF_PC = '0; bus.IF_Hit = 1'b0; bus.IF_JumpPredict = 1'b0;
    bus.IF_PredTarget = '0; bus.Stall = 1'b0; bus.EX_IsBranch = 1'b0;
    bus.EX_Taken = 1'b0; bus.EX_Target = '0;
    repeat (2) @(posedge clk);

    step("reset", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, z(16'd0, 16'd0));

    // Correctly predicted taken branch.
    fetch("t1_fetch", 32'h100, 1'b1, 1'b1, 32'h200, z(16'd0, 16'd0));
    idle("t1_idle", z(16'd0, 16'd0));
    resolve("t1_resolve", 1'b0, 1'b1, 1'b1, 32'h200,
            r(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 16'd0, 16'd0));

    // Predicted taken, actually not taken; younger fetch in the same cycle is dropped.
    fetch("t2_fetch", 32'h100, 1'b1, 1'b1, 32'h200, z(16'd1, 16'd0));
    idle("t2_idle", z(16'd1, 16'd0));
    step("t2_mispredict", 1'b0, 1'b1, 32'h500, 1'b1, 1'b1, 32'h600, 1'b0, 1'b1, 1'b0, 32'h200,
         r(1'b1, 32'h104, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 16'd1, 16'd0));
    resolve("t2_flushed_a", 1'b0, 1'b1, 1'b1, 32'h999, z(16'd2, 16'd1));
    resolve("t2_flushed_b", 1'b0, 1'b1, 1'b1, 32'h999, z(16'd2, 16'd1));

    // BTB miss on a taken branch allocates the entry.
    fetch("t3_fetch", 32'h300, 1'b0, 1'b0, 32'h0, z(16'd2, 16'd1));
    idle("t3_idle", z(16'd2, 16'd1));
    resolve("t3_btb_alloc", 1'b0, 1'b1, 1'b1, 32'h400,
            r(1'b1, 32'h400, 1'b0, 1'b0, 1'b1, 32'h300, 32'h400, 16'd2, 16'd1));
    idle("t3_after", z(16'd3, 16'd2));

    // Stall for three cycles with a mispredicting branch in EX, then release once.
    fetch("t4_fetch", 32'h700, 1'b1, 1'b1, 32'h800, z(16'd3, 16'd2));
    idle("t4_idle", z(16'd3, 16'd2));
    for (int i = 0; i < 3; i++) begin
      step("t4_stall", 1'b0, 1'b1, 32'h900, 1'b1, 1'b1, 32'hA00, 1'b1, 1'b1, 1'b0, 32'h800,
           z(16'd3, 16'd2));
    end
    resolve("t4_release", 1'b0, 1'b1, 1'b0, 32'h800,
            r(1'b1, 32'h704, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 16'd3, 16'd2));
    idle("t4_once_a", z(16'd4, 16'd3));
    idle("t4_once_b", z(16'd4, 16'd3));

    // BTB hit, taken, but stale target.
    fetch("t5_fetch", 32'h1000, 1'b1, 1'b1, 32'h2000, z(16'd4, 16'd3));
    idle("t5_idle", z(16'd4, 16'd3));
    resolve("t5_wrong_target", 1'b0, 1'b1, 1'b1, 32'h3000,
            r(1'b1, 32'h3000, 1'b1, 1'b1, 1'b1, 32'h1000, 32'h3000, 16'd4, 16'd3));
    idle("t5_after", z(16'd5, 16'd4));

    // Stale BTB entry on a non-branch at the top of the address space.
    fetch("t6_fetch", 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h40, z(16'd5, 16'd4));
    idle("t6_idle", z(16'd5, 16'd4));
    resolve("t6_pc_wrap", 1'b0, 1'b0, 1'b0, 32'h0,
            r(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 16'd5, 16'd4));
    idle("t6_after", z(16'd5, 16'd5));

    // Non-branch with a hit but not-taken prediction is silent.
    fetch("t7_fetch", 32'h2000, 1'b1, 1'b0, 32'h2400, z(16'd5, 16'd5));
    idle("t7_idle", z(16'd5, 16'd5));
    resolve("t7_quiet", 1'b0, 1'b0, 1'b0, 32'h0, z(16'd5, 16'd5));
    idle("t7_after", z(16'd5, 16'd5));

    // Branch hit, predicted not taken, actually not taken.
    fetch("t8_fetch", 32'h2100, 1'b1, 1'b0, 32'h2200, z(16'd5, 16'd5));
    idle("t8_idle", z(16'd5, 16'd5));
    resolve("t8_nt_correct", 1'b0, 1'b1, 1'b0, 32'h2200,
            r(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 16'd5, 16'd5));
    idle("t8_after", z(16'd6, 16'd5));

    // Reset coinciding with a mispredict.
    fetch("t9_fetch", 32'h100, 1'b1, 1'b1, 32'h200, z(16'd6, 16'd5));
    idle("t9_idle", z(16'd6, 16'd5));
    step("t9_reset_mis", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h200,
         r(1'b1, 32'h104, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 16'd6, 16'd5));
    resolve("t9_after_a", 1'b0, 1'b1, 1'b1, 32'h999, z(16'd0, 16'd0));
    resolve("t9_after_b", 1'b0, 1'b1, 1'b1, 32'h999, z(16'd0, 16'd0));

    // Back-to-back correct branches walk BranchCount through 0xFFFF -> 0x0000.
    for (int k = 0; k < L; k++) begin
      step("wrap_stream", 1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 32'h200,
           (k < 2) ? z(16'd0, 16'd0)
                   : r(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 16'(k - 2), 16'd0));
    end
    resolve("wrap_drain_a", 1'b0, 1'b1, 1'b1, 32'h200,
            r(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 16'(L - 2), 16'd0));
    resolve("wrap_drain_b", 1'b0, 1'b1, 1'b1, 32'h200,
            r(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 16'(L - 1), 16'd0));
    idle("wrap_end", z(16'(L), 16'd0));

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got pending=%0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
